// File: rtl/interrupt_controller.sv
// interrupt_controller: masks pending sources, vectors the highest-priority one to the core,
// and runs the IRQ/ACK/RETI handshake with an acknowledge timeout.
module interrupt_controller #(
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [7:0] MASK_RESET  = 8'hFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] State,
  input  logic       Global_En,
  input  logic       Mask_We,
  input  logic [7:0] Mask_In,
  input  logic       Int_Ack,
  input  logic       RETI,
  output logic       IRQ,
  output logic [2:0] Int_Vector,
  output logic [7:0] Int_Clear,
  output logic [7:0] Mask,
  output logic       Busy,
  output logic       Timeout_Err
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_e;
  state_e     state_q, state_d;
  logic       irq_q, irq_d, busy_q, busy_d, terr_q, terr_d;
  logic [2:0] vec_q, vec_d, win;
  logic [7:0] clr_q, clr_d, mask_q, mask_d, cnt_q, cnt_d, pending;
  assign pending = State & mask_q;
  always_comb begin
    win = '0;
    for (int i = 0; i < 8; i++) if (pending[i]) win = 3'(i);
  end
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    clr_d   = '0;
    busy_d  = busy_q;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
    mask_d  = Mask_We ? Mask_In : mask_q;
    case (state_q)
      IDLE: if (Global_En && |pending) begin
        vec_d   = win;
        irq_d   = 1'b1;
        cnt_d   = '0;
        state_d = ASSERT;
      end
      ASSERT: begin
        // Ack beats enable drop, which beats the timeout
        if (Int_Ack) begin
          irq_d   = 1'b0;
          clr_d   = 8'b1 << vec_q;
          busy_d  = 1'b1;
          state_d = SERVICE;
        end else if (!Global_En) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          irq_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      SERVICE: if (RETI) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      clr_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= MASK_RESET;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end
  assign IRQ         = irq_q;
  assign Int_Vector  = vec_q;
  assign Int_Clear   = clr_q;
  assign Mask        = mask_q;
  assign Busy        = busy_q;
  assign Timeout_Err = terr_q;
endmodule
